multicycle_controller: RTL and testbench

Multi-cycle control unit for the RISC-V core. It sequences the shared 32-bit ALU, the instruction/data memory port, the PC and the register file through a Moore FSM, and it drives the 3-bit ALUControl encoding the ALU consumes. It decodes `op`/`funct3`/`funct7b5` of the latched instruction and uses the ALU Flags zero bit to resolve `beq`. It also keeps a retired-instruction counter for bring-up and debug.

---
 rtl/multicycle_controller.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RISC-V core: sequences ALU, memory port, PC, register file.
// Latency: 2..5 cycles per instruction (FETCH inclusive); outputs decode the current state register.
// Backpressure: none; free-running sequencer with no stall input, synchronous active-high reset.
module multicycle_controller #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic [3:0]           Flags,
   output logic                 PCWrite,
   output logic                 AdrSrc,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ImmSrc,
   output logic                 RegWrite,
   output logic [2:0]           ALUControl,
   output logic [3:0]           state,
   output logic [CNT_WIDTH-1:0] instret
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   state_t               r_state;
   logic [CNT_WIDTH-1:0] r_instret;

   state_t     w_next;
   logic       w_retire;
   logic       w_pc_update;
   logic       w_branch;
   logic [1:0] w_alu_op;
   logic       w_irwrite;
   logic       w_memwrite;
   logic       w_regwrite;
   // Only the Zero flag steers control; the other ALU flags are ignored here.
   logic       w_unused_flags;

   assign w_unused_flags = ^{Flags[3], Flags[1:0]};

   // Next-state selection; unused encodings fall back to FETCH.
   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:    w_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_EXECUTER;
               OP_I:         w_next = S_EXECUTEI;
               OP_BEQ:       w_next = S_BEQ;
               OP_JAL:       w_next = S_JAL;
               default:      w_next = S_FETCH;
            endcase
         end
         S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_next = S_MEMWB;
         S_EXECUTER: w_next = S_ALUWB;
         S_EXECUTEI: w_next = S_ALUWB;
         S_JAL:      w_next = S_ALUWB;
         default:    w_next = S_FETCH;
      endcase
   end

   // An instruction retires on the edge leaving its final state.
   assign w_retire = (r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                     (r_state == S_ALUWB) || (r_state == S_BEQ);

   // State register and retired-instruction counter; reset aborts any instruction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_instret <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) begin
            r_instret <= r_instret + CNT_WIDTH'(1);
         end
      end
   end

   // Moore output decode of the current state.
   always_comb begin
      w_pc_update = 1'b0;
      w_branch    = 1'b0;
      w_alu_op    = 2'b00;
      w_irwrite   = 1'b0;
      w_memwrite  = 1'b0;
      w_regwrite  = 1'b0;
      AdrSrc      = 1'b0;
      ResultSrc   = 2'b00;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      case (r_state)
         S_FETCH: begin
            w_irwrite   = 1'b1;
            ALUSrcB     = 2'b10;
            ResultSrc   = 2'b10;
            w_pc_update = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc  = 2'b01;
            w_regwrite = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc     = 1'b1;
            w_memwrite = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA  = 2'b10;
            w_alu_op = 2'b10;
         end
         S_EXECUTEI: begin
            ALUSrcA  = 2'b10;
            ALUSrcB  = 2'b01;
            w_alu_op = 2'b10;
         end
         S_ALUWB: w_regwrite = 1'b1;
         S_BEQ: begin
            ALUSrcA  = 2'b10;
            w_alu_op = 2'b01;
            w_branch = 1'b1;
         end
         S_JAL: begin
            ALUSrcA     = 2'b01;
            ALUSrcB     = 2'b10;
            w_pc_update = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // ALU decoder: op[5] separates register (sub-capable) from immediate forms.
   always_comb begin
      ALUControl = 3'b000;
      case (w_alu_op)
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   // Immediate format follows the opcode of the latched instruction.
   always_comb begin
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   // Write strobes are suppressed while reset is held so an aborted instruction leaves no side effects.
   assign PCWrite  = ~reset & (w_pc_update | (w_branch & Flags[2]));
   assign IRWrite  = ~reset & w_irwrite;
   assign MemWrite = ~reset & w_memwrite;
   assign RegWrite = ~reset & w_regwrite;

   assign state   = r_state;
   assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected control words queued per instruction.
// Latency: expected entries are popped one per cycle on the falling edge.
// Backpressure: none; the DUT never stalls, so the queue drains at one entry per cycle.
module tb_multicycle_controller;

   localparam int CW = 4;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BEQ = 7'b1100011;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       adr;
      logic       memw;
      logic       irw;
      logic [1:0] res;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [1:0] imm;
      logic       regw;
      logic [2:0] aluc;
   } ctrl_t;

   typedef struct packed {
      ctrl_t         c;
      logic [CW-1:0] cnt;
   } entry_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [6:0]    op;
   logic [2:0]    funct3;
   logic          funct7b5;
   logic [3:0]    Flags;
   logic          PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0]    ALUControl;
   logic [3:0]    state;
   logic [CW-1:0] instret;

   int            checks = 0;
   int            errors = 0;
   entry_t        sb_q[$];
   logic [CW-1:0] exp_cnt;

   multicycle_controller #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Flags(Flags),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .RegWrite(RegWrite), .ALUControl(ALUControl), .state(state), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected control word for one state of an instruction, straight from the state table.
   function automatic ctrl_t model(input logic [3:0] st, input logic [6:0] o, input logic [2:0] f3,
                                   input logic f7, input logic z);
      ctrl_t      c;
      logic       pcupd;
      logic       br;
      logic [1:0] aop;
      c = '0; pcupd = 1'b0; br = 1'b0; aop = 2'b00;
      c.st = st;
      case (st)
         4'd0:  begin c.irw = 1'b1; c.sb = 2'b10; c.res = 2'b10; pcupd = 1'b1; end
         4'd1:  begin c.sa = 2'b01; c.sb = 2'b01; end
         4'd2:  begin c.sa = 2'b10; c.sb = 2'b01; end
         4'd3:  c.adr = 1'b1;
         4'd4:  begin c.res = 2'b01; c.regw = 1'b1; end
         4'd5:  begin c.adr = 1'b1; c.memw = 1'b1; end
         4'd6:  begin c.sa = 2'b10; aop = 2'b10; end
         4'd7:  begin c.sa = 2'b10; c.sb = 2'b01; aop = 2'b10; end
         4'd8:  c.regw = 1'b1;
         4'd9:  begin c.sa = 2'b10; aop = 2'b01; br = 1'b1; end
         4'd10: begin c.sa = 2'b01; c.sb = 2'b10; pcupd = 1'b1; end
         default: ;
      endcase
      c.pcw = pcupd | (br & z);
      if (o == SW) c.imm = 2'b01;
      else if (o == BEQ) c.imm = 2'b10;
      else if (o == JAL) c.imm = 2'b11;
      else c.imm = 2'b00;
      if (aop == 2'b01) c.aluc = 3'b001;
      else if (aop == 2'b10) begin
         if (f3 == 3'b000) c.aluc = (o == RT && f7) ? 3'b001 : 3'b000;
         else if (f3 == 3'b010) c.aluc = 3'b101;
         else if (f3 == 3'b110) c.aluc = 3'b011;
         else if (f3 == 3'b111) c.aluc = 3'b010;
         else c.aluc = 3'b000;
      end
      return c;
   endfunction

   // Called one step after the edge that enters FETCH; leaves one step after the edge back into FETCH.
   // stop_at > 0 runs only that many cycles of the instruction (it is then not counted).
   task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input logic [3:0] fl, input int stop_at);
      int     seq[$];
      logic   counted;
      entry_t e;
      op = o; funct3 = f3; funct7b5 = f7; Flags = fl;
      counted = 1'b1;
      case (o)
         LW:      seq = '{0, 1, 2, 3, 4};
         SW:      seq = '{0, 1, 2, 5};
         RT:      seq = '{0, 1, 6, 8};
         IT:      seq = '{0, 1, 7, 8};
         JAL:     seq = '{0, 1, 10, 8};
         BEQ:     seq = '{0, 1, 9};
         default: begin seq = '{0, 1}; counted = 1'b0; end
      endcase
      if (stop_at > 0) begin
         while (seq.size() > stop_at) void'(seq.pop_back());
         counted = 1'b0;
      end
      foreach (seq[i]) begin
         e.c   = model(4'(seq[i]), o, f3, f7, fl[2]);
         e.cnt = exp_cnt;
         sb_q.push_back(e);
      end
      if (counted) exp_cnt = exp_cnt + 1'b1;
      repeat (seq.size()) @(posedge clk);
      #1;
   endtask

   // Scoreboard: compare each cycle's outputs against the head of the expected queue.
   always @(negedge clk) begin
      if (sb_q.size() != 0) begin
         entry_t e;
         e = sb_q.pop_front();
         chk("state", 32'(state), 32'(e.c.st));
         chk("ctrl", 32'({state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                            ALUSrcB, ImmSrc, RegWrite, ALUControl}), 32'(e.c));
         chk("instret", 32'(instret), 32'(e.cnt));
      end
   end

   initial begin
      reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Flags = 4'd0;
      exp_cnt = '0;
      // Reset held: state FETCH, counter clear, all write strobes low.
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_state", 32'(state), 32'd0);
         chk("rst_instret", 32'(instret), 32'd0);
         chk("rst_strobes", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
      end
      @(posedge clk);
      #1 reset = 1'b0;

      run(LW,  3'b010, 1'b0, 4'b0100, 0);   // Zero set outside BEQ must not move the PC
      run(SW,  3'b010, 1'b0, 4'b0000, 0);
      run(RT,  3'b000, 1'b1, 4'b0000, 0);   // sub
      run(RT,  3'b000, 1'b0, 4'b0000, 0);   // add
      run(RT,  3'b110, 1'b0, 4'b0000, 0);   // or
      run(RT,  3'b111, 1'b0, 4'b0000, 0);   // and
      run(RT,  3'b010, 1'b0, 4'b0000, 0);   // slt
      run(IT,  3'b000, 1'b1, 4'b0000, 0);   // addi with bit30 set stays add
      run(IT,  3'b001, 1'b0, 4'b0000, 0);   // unhandled funct3 -> add
      run(BEQ, 3'b000, 1'b0, 4'b0100, 0);   // taken
      run(BEQ, 3'b000, 1'b0, 4'b0000, 0);   // not taken
      run(BEQ, 3'b000, 1'b0, 4'b1011, 0);   // other flags set, Zero clear
      run(JAL, 3'b000, 1'b0, 4'b0000, 0);
      run(BAD, 3'b000, 1'b0, 4'b0100, 0);   // unsupported: 2 cycles, not counted

      // Abort a store in MEMWRITE with reset.
      run(SW, 3'b010, 1'b0, 4'b0000, 3);
      chk("abort_pre_state", 32'(state), 32'd5);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_memwrite", 32'(MemWrite), 32'd0);
      chk("abort_adrsrc", 32'(AdrSrc), 32'd1);
      chk("abort_state_hold", 32'(state), 32'd5);
      @(posedge clk);
      #1;
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_instret", 32'(instret), 32'd0);
      reset = 1'b0;
      exp_cnt = '0;

      // Fill the counter to all-ones, then one store wraps it.
      for (int i = 0; i < 15; i++) begin
         case (i % 3)
            0: run(IT, 3'b111, 1'b0, 4'b0000, 0);
            1: run(BEQ, 3'b000, 1'b0, 4'(i), 0);
            default: run(RT, 3'b000, 1'(i), 4'b0000, 0);
         endcase
      end
      chk("full_count", 32'(instret), 32'd15);
      run(SW, 3'b010, 1'b0, 4'b0000, 0);
      chk("wrap", 32'(instret), 32'd0);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
